// File: rtl/pb_gen_pkg.sv
// Shared types and helpers for the push-button press generator.
package pb_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_DN,
    HOLD,
    BOUNCE_UP,
    GAP
  } pb_gen_state_t;

  // Level of an untouched active-low button
  localparam logic PB_IDLE_LVL = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter that parks at zero; expired is registered and mirrors count==0.
module cyc_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = '0;
    if (load) begin
      count_nxt = load_val;
    end else if (count != '0) begin
      count_nxt = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b1;
    end else begin
      count   <= count_nxt;
      expired <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/pb_press_gen.sv
// Active-low push-button emulator: timed press/release with optional contact bounce,
// a one-cycle released pulse on the final rise and an enforced gap between presses.
module pb_press_gen
  import pb_gen_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES  = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned GLITCHES      = 0,
  parameter int unsigned BOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic PB_out,
  output logic busy,
  output logic released
);

  localparam int unsigned TMR_W  = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, BOUNCE_CYCLES) + 1);
  localparam int unsigned GCNT_W = (GLITCHES > 0) ? $clog2(GLITCHES + 1) : 1;
  localparam bit          HAS_GLITCH = (GLITCHES > 0);

  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(PRESS_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] BOUNCE_LD = TMR_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GLITCHES > 0) ? GLITCHES - 1 : 0);

  pb_gen_state_t     state, state_nxt;
  logic              pb_nxt, busy_nxt, rel_nxt;
  logic [GCNT_W-1:0] gcnt, gcnt_nxt;
  logic              tmr_load, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;
  logic              to_gap;

  cyc_timer #(
    .W(TMR_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      PB_out   <= PB_IDLE_LVL;
      busy     <= 1'b0;
      released <= 1'b0;
      gcnt     <= '0;
    end else begin
      state    <= state_nxt;
      PB_out   <= pb_nxt;
      busy     <= busy_nxt;
      released <= rel_nxt;
      gcnt     <= gcnt_nxt;
    end
  end

  // Within bounce phases the current PB_out level tells which half-period is running
  always_comb begin
    state_nxt = state;
    pb_nxt    = PB_out;
    busy_nxt  = busy;
    rel_nxt   = 1'b0;
    gcnt_nxt  = gcnt;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    to_gap    = 1'b0;

    if (abort && (state inside {BOUNCE_DN, HOLD, BOUNCE_UP})) begin
      to_gap = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort && !busy) begin
            pb_nxt   = ~PB_IDLE_LVL;
            busy_nxt = 1'b1;
            tmr_load = 1'b1;
            gcnt_nxt = '0;
            if (HAS_GLITCH) begin
              state_nxt = BOUNCE_DN;
              tmr_val   = BOUNCE_LD;
            end else begin
              state_nxt = HOLD;
              tmr_val   = HOLD_LD;
            end
          end
        end
        BOUNCE_DN: begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = BOUNCE_LD;
            if (PB_out != PB_IDLE_LVL) begin
              pb_nxt = PB_IDLE_LVL;
            end else begin
              pb_nxt = ~PB_IDLE_LVL;
              if (gcnt == GCNT_LAST) begin
                state_nxt = HOLD;
                tmr_val   = HOLD_LD;
              end else begin
                gcnt_nxt = gcnt + GCNT_W'(1);
              end
            end
          end
        end
        HOLD: begin
          if (tmr_expired) begin
            if (HAS_GLITCH) begin
              state_nxt = BOUNCE_UP;
              pb_nxt    = PB_IDLE_LVL;
              gcnt_nxt  = '0;
              tmr_load  = 1'b1;
              tmr_val   = BOUNCE_LD;
            end else begin
              to_gap  = 1'b1;
              rel_nxt = 1'b1;
            end
          end
        end
        BOUNCE_UP: begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = BOUNCE_LD;
            if (PB_out == PB_IDLE_LVL) begin
              pb_nxt = ~PB_IDLE_LVL;
            end else if (gcnt == GCNT_LAST) begin
              to_gap  = 1'b1;
              rel_nxt = 1'b1;
            end else begin
              pb_nxt   = PB_IDLE_LVL;
              gcnt_nxt = gcnt + GCNT_W'(1);
            end
          end
        end
        GAP: begin
          if (tmr_expired) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          pb_nxt    = PB_IDLE_LVL;
          busy_nxt  = 1'b0;
        end
      endcase
    end

    // Final release and abort both land in a full-length gap with the button up
    if (to_gap) begin
      state_nxt = GAP;
      pb_nxt    = PB_IDLE_LVL;
      busy_nxt  = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = GAP_LD;
    end
  end

endmodule
